// File: rtl/alu_md_if.sv
// alu_md_if: EX-stage instruction fields, operands and ALU/M-unit results
interface alu_md_if #(parameter int XLEN = 32);
   logic [2:0] ALUOp;
   logic [2:0] funct3;
   logic funct7_5, funct7_0, valid_in, kill;
   logic [XLEN-1:0] opA, opB;
   logic [3:0] ALU_control;
   logic md_op, stall, md_done;
   logic [XLEN-1:0] md_result;
   modport master (
      output ALUOp, funct3, funct7_5, funct7_0, valid_in, kill, opA, opB,
      input ALU_control, md_op, stall, md_done, md_result
   );
   modport slave (
      input ALUOp, funct3, funct7_5, funct7_0, valid_in, kill, opA, opB,
      output ALU_control, md_op, stall, md_done, md_result
   );
endinterface

// File: rtl/alu_md_control.sv
// alu_md_control: RV32 ALU control decode plus iterative RV32M multiply/divide unit
module alu_md_control #(
   parameter int XLEN = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic CLK,
   input logic RST,
   alu_md_if.slave bus
);
   localparam int N = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [XLEN-1:0] a, b, m, res, abs_a, abs_b, spec_res, fix_res, qr;
   logic [2*XLEN-1:0] acc, acc_run, prod;
   logic [XLEN:0] t;
   logic [2:0] f3;
   logic [3:0] rdec, bdec;
   logic neg, is_div, sa, sb, div0, ovf;
   always_comb begin
      case (bus.funct3)
         3'b000: rdec = (bus.funct7_5 && bus.ALUOp == 3'b000) ? 4'b0001 : 4'b0000;
         3'b001: rdec = 4'b0101;
         3'b010: rdec = 4'b1001;
         3'b011: rdec = 4'b1000;
         3'b100: rdec = 4'b0100;
         3'b101: rdec = bus.funct7_5 ? 4'b0111 : 4'b0110;
         3'b110: rdec = 4'b0011;
         default: rdec = 4'b0010;
      endcase
      case (bus.funct3)
         3'b000: bdec = 4'b0001;
         3'b001: bdec = 4'b1010;
         3'b100, 3'b101: bdec = 4'b1001;
         3'b110, 3'b111: bdec = 4'b1000;
         default: bdec = 4'b0000;
      endcase
   end
   assign bus.md_op = bus.ALUOp == 3'b000 && bus.funct7_0;
   assign bus.ALU_control = bus.md_op ? 4'b0000 :
                            (bus.ALUOp == 3'b000 || bus.ALUOp == 3'b011) ? rdec :
                            bus.ALUOp == 3'b001 ? bdec : 4'b0000;
   assign bus.stall = bus.valid_in && bus.md_op && state != DONE;
   assign bus.md_done = state == DONE;
   assign bus.md_result = res;
   // Operand signedness: MULHU and the unsigned divides see raw bits; MULHSU signs only opA
   assign is_div = f3[2];
   assign sa = (is_div ? !f3[0] : f3 != 3'b011) && a[XLEN-1];
   assign sb = (is_div ? !f3[0] : !f3[1]) && b[XLEN-1];
   assign abs_a = sa ? -a : a;
   assign abs_b = sb ? -b : b;
   assign div0 = is_div && b == '0;
   assign ovf = is_div && !f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
   assign spec_res = div0 ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);
   assign prod = neg ? -acc : acc;
   assign qr = f3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
   assign fix_res = is_div ? (neg ? -qr : qr) :
                    (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide
   always_comb begin
      acc_run = acc;
      t = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (is_div) begin
            t = {acc_run[2*XLEN-1:XLEN], acc_run[XLEN-1]} - {1'b0, m};
            acc_run = t[XLEN] ? {acc_run[2*XLEN-2:0], 1'b0} : {t[XLEN-1:0], acc_run[XLEN-2:0], 1'b1};
         end else begin
            t = {1'b0, acc_run[2*XLEN-1:XLEN]} + (acc_run[0] ? {1'b0, m} : '0);
            acc_run = {t, acc_run[XLEN-1:1]};
         end
      end
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      case (state)
         IDLE: state_nxt = (bus.valid_in && bus.md_op && !bus.kill) ? PREP : IDLE;
         PREP: begin
            state_nxt = (div0 || ovf) ? DONE : RUN;
            cnt_nxt = CW'(N);
         end
         RUN: begin
            cnt_nxt = cnt - 1'b1;
            state_nxt = cnt == CW'(1) ? FIX : RUN;
         end
         FIX: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (bus.kill && state != IDLE) state_nxt = IDLE;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
         a <= '0;
         b <= '0;
         m <= '0;
         f3 <= '0;
         acc <= '0;
         neg <= 1'b0;
         res <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         if (state == IDLE && state_nxt == PREP) begin
            a <= bus.opA;
            b <= bus.opB;
            f3 <= bus.funct3;
         end
         if (state == PREP) begin
            m <= is_div ? abs_b : abs_a;
            acc <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
            neg <= (is_div && f3[1]) ? sa : sa ^ sb;
         end
         if (state == RUN) acc <= acc_run;
         if (state_nxt == DONE) res <= state == PREP ? spec_res : fix_res;
      end
   end
endmodule

// File: tb/tb_alu_md_control.sv
// tb_alu_md_control: reference-model bench for one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=4 unit
module tb_alu_md_control;
   logic CLK = 1'b0, RST = 1'b1;
   logic [2:0] aluop = '0, f3 = '0;
   logic f75 = 1'b0, f70 = 1'b0, valid = 1'b0, kill = 1'b0;
   logic [31:0] opa = '0, opb = '0;
   int checks = 0, errors = 0;
   bit live = 1'b0;

   alu_md_if #(.XLEN(32)) i1 ();
   alu_md_if #(.XLEN(32)) i4 ();
   assign i1.ALUOp = aluop;   assign i4.ALUOp = aluop;
   assign i1.funct3 = f3;     assign i4.funct3 = f3;
   assign i1.funct7_5 = f75;  assign i4.funct7_5 = f75;
   assign i1.funct7_0 = f70;  assign i4.funct7_0 = f70;
   assign i1.valid_in = valid; assign i4.valid_in = valid;
   assign i1.kill = kill;     assign i4.kill = kill;
   assign i1.opA = opa;       assign i4.opA = opa;
   assign i1.opB = opb;       assign i4.opB = opb;

   alu_md_control #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (.CLK(CLK), .RST(RST), .bus(i1));
   alu_md_control #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (.CLK(CLK), .RST(RST), .bus(i4));

   always #5 CLK = ~CLK;

   logic [1:0] done_v, stall_v, mdop_v;
   logic [31:0] res_v [2];
   logic [3:0] ctl_v [2];
   assign done_v = {i4.md_done, i1.md_done};
   assign stall_v = {i4.stall, i1.stall};
   assign mdop_v = {i4.md_op, i1.md_op};
   assign res_v[0] = i1.md_result;
   assign res_v[1] = i4.md_result;
   assign ctl_v[0] = i1.ALU_control;
   assign ctl_v[1] = i4.ALU_control;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [3:0] dec_ref(input logic [2:0] op, input logic [2:0] f, input logic s5, input logic s0);
      logic [31:0] rt, bt;
      logic [3:0] v;
      rt = 32'h2364_8950;
      bt = 32'h8899_00A1;
      v = rt[f*4 +: 4];
      case (op)
         3'd0: return s0 ? 4'h0 : (s5 && f == 3'd0) ? 4'h1 : (s5 && f == 3'd5) ? 4'h7 : v;
         3'd3: return (s5 && f == 3'd5) ? 4'h7 : v;
         3'd1: return bt[f*4 +: 4];
         default: return 4'h0;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      return f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      logic [63:0] p;
      logic signed [31:0] qx, qy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      qx = x;
      qy = y;
      case (f)
         3'd0, 3'd1: p = sx * sy;
         3'd2: p = sx * $signed({32'b0, y});
         3'd3: p = {32'b0, x} * {32'b0, y};
         default: p = '0;
      endcase
      if (f == 3'd0) return p[31:0];
      if (!f[2]) return p[63:32];
      if (y == 0) return f[1] ? x : 32'hFFFF_FFFF;
      if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f[1] ? 32'h0 : x;
      case (f[1:0])
         2'd0: return qx / qy;
         2'd1: return x / y;
         2'd2: return qx % qy;
         default: return x % y;
      endcase
   endfunction

   // model per unit: cycle index since accept (accept cycle = 0) and the cycle md_done is due
   bit busy [2];
   int cnt [2], lat [2];
   logic [31:0] eres [2], held [2];

   always @(posedge CLK)
      for (int i = 0; i < 2; i++) begin
         if (RST) begin
            busy[i] <= 1'b0;
            held[i] <= '0;
         end else if (busy[i]) begin
            if (cnt[i] == lat[i]) begin
               held[i] <= eres[i];
               busy[i] <= 1'b0;
            end else if (kill) busy[i] <= 1'b0;
            else cnt[i] <= cnt[i] + 1;
         end else if (valid && aluop == 3'd0 && f70 && !kill) begin
            busy[i] <= 1'b1;
            cnt[i] <= 1;
            eres[i] <= md_ref(f3, opa, opb);
            lat[i] <= is_special(f3, opa, opb) ? 2 : (i == 0 ? 32 : 8) + 3;
         end
      end

   always @(negedge CLK)
      if (live)
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("ctl%0d", i), 32'(ctl_v[i]), 32'(dec_ref(aluop, f3, f75, f70)));
            chk($sformatf("md_op%0d", i), 32'(mdop_v[i]), 32'(aluop == 3'd0 && f70));
            chk($sformatf("stall%0d", i), 32'(stall_v[i]),
                32'(valid && aluop == 3'd0 && f70 && !(busy[i] && cnt[i] == lat[i])));
            chk($sformatf("md_done%0d", i), 32'(done_v[i]), 32'(busy[i] && cnt[i] == lat[i]));
            chk($sformatf("md_result%0d", i), res_v[i], (busy[i] && cnt[i] == lat[i]) ? eres[i] : held[i]);
         end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic dec(input logic [2:0] op, input logic [2:0] f, input logic s5, input logic s0,
                      input logic [3:0] exp, input logic exp_md);
      tick();
      valid = 1'b0;
      aluop = op;
      f3 = f;
      f75 = s5;
      f70 = s0;
      @(negedge CLK);
      chk("dec ctl", 32'(ctl_v[0]), 32'(exp));
      chk("dec md_op", 32'(mdop_v[0]), 32'(exp_md));
   endtask

   task automatic run_md(input int sel, input string name, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_cyc);
      int cyc, st;
      tick();
      aluop = 3'd0;
      f70 = 1'b1;
      f75 = 1'b0;
      kill = 1'b0;
      f3 = f;
      opa = x;
      opb = y;
      valid = 1'b1;
      cyc = -1;
      st = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (stall_v[sel]) st++;
         if (done_v[sel]) begin
            cyc = c;
            break;
         end
      end
      chk({name, " done cycle"}, cyc, exp_cyc);
      chk({name, " result"}, res_v[sel], exp);
      chk({name, " stall cycles"}, st, exp_cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int nd;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      live = 1'b1;
      @(negedge CLK);
      chk("reset result0", res_v[0], 32'h0);
      chk("reset result1", res_v[1], 32'h0);
      chk("reset done", 32'(done_v), 32'h0);
      chk("reset stall", 32'(stall_v), 32'h0);

      dec(3'b000, 3'b101, 1'b1, 1'b0, 4'b0111, 1'b0);
      dec(3'b001, 3'b001, 1'b0, 1'b0, 4'b1010, 1'b0);
      dec(3'b011, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0);
      dec(3'b110, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0);
      dec(3'b000, 3'b000, 1'b1, 1'b0, 4'b0001, 1'b0);
      dec(3'b011, 3'b101, 1'b1, 1'b0, 4'b0111, 1'b0);
      dec(3'b001, 3'b100, 1'b0, 1'b0, 4'b1001, 1'b0);
      dec(3'b001, 3'b111, 1'b0, 1'b0, 4'b1000, 1'b0);
      dec(3'b000, 3'b011, 1'b0, 1'b0, 4'b1000, 1'b0);
      dec(3'b010, 3'b111, 1'b1, 1'b0, 4'b0000, 1'b0);
      dec(3'b000, 3'b110, 1'b0, 1'b1, 4'b0000, 1'b1);
      for (int v = 0; v < 256; v++) begin
         tick();
         {aluop, f3, f75, f70} = v[7:0];
      end

      run_md(0, "MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
      run_md(0, "DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
      run_md(0, "MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
      run_md(0, "MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
      run_md(0, "MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 35);
      run_md(0, "REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
      run_md(0, "REM neg divisor", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
      run_md(0, "DIVU by zero", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 2);
      run_md(0, "REMU by zero", 3'd7, 32'd100, 32'd0, 32'd100, 2);
      run_md(0, "DIV overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      run_md(0, "REM overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);
      run_md(0, "DIV by zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
      run_md(0, "DIVU", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 35);

      // kill a DIV in its tenth cycle
      tick();
      f3 = 3'd4;
      opa = 32'd100;
      opb = 32'd7;
      repeat (10) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      valid = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge CLK);
         if (done_v[0]) nd++;
      end
      chk("kill no md_done", nd, 0);
      chk("kill result held", res_v[0], 32'h7FFF_FFFC);

      // synchronous reset in the tenth cycle of a MUL
      tick();
      f3 = 3'd0;
      opa = 32'd3;
      opb = 32'd5;
      valid = 1'b1;
      repeat (10) tick();
      RST = 1'b1;
      repeat (2) begin
         tick();
         @(negedge CLK);
         chk("rst result", res_v[0], 32'h0);
         chk("rst stall", 32'(stall_v[0]), 32'h1);
         chk("rst done", 32'(done_v[0]), 32'h0);
      end
      tick();
      RST = 1'b0;
      valid = 1'b0;
      repeat (40) tick();

      run_md(1, "MUL x4", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 11);
      run_md(1, "DIV x4", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 11);
      tick();
      valid = 1'b0;
      nd = 0;
      repeat (20) begin
         @(negedge CLK);
         if (done_v[1]) nd++;
      end
      chk("x4 no extra md_done", nd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
- Successor to the ALU control decoder for the RV32 core: keeps the combinational ALUOp/funct decode to the 4-bit ALU_control code.
- Adds a parametrised iterative multiply/divide unit for the RV32M extension.
- Sits in EX beside the ALU. For M-ops it runs a multi-cycle FSM and holds stall high until the result is ready.

Parameters:
- XLEN, 32, operand/result width.
- BITS_PER_CYCLE, 1, multiplier/divider bits retired per RUN cycle. Legal values 1, 2, 4; must divide XLEN.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- ALUOp  in  3  instruction class from main control
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- funct7_0  in  1  instr[25], M-extension select
- valid_in  in  1  EX holds a valid instruction this cycle
- kill  in  1  flush; aborts any M-op in progress
- opA  in  XLEN  rs1 value
- opB  in  XLEN  rs2 value
- ALU_control  out  4  ALU operation code (combinational)
- md_op  out  1  current instruction is an M-op (combinational)
- stall  out  1  freeze IF/ID/EX (combinational)
- md_done  out  1  one-cycle pulse, md_result valid
- md_result  out  XLEN  M-op result, held until next accept

Behaviour:
- Interface fixed: one clock CLK; RST is synchronous and active-high.
- Decode (combinational) for ALUOp=000, funct7_0=0 (R-type):
  - funct3 000: ADD 0000, or SUB 0001 if funct7_5.
  - 001 SLL 0101; 010 SLT 1001; 011 SLTU 1000; 100 XOR 0100.
  - 101: SRL 0110, or SRA 0111 if funct7_5.
  - 110 OR 0011; 111 AND 0010.
- Decode for other ALUOp values:
  - ALUOp=011 (I-type): same as R-type, except funct3 000 is always ADD; SRA/SRL selected by funct7_5 only at funct3 101.
  - ALUOp=010 (load/store) and 100 (LUI/AUIPC): ADD.
  - ALUOp=001 (branch): 000 SUB; 001 1010; 100/101 SLT; 110/111 SLTU; other funct3 ADD.
  - Any other ALUOp: ADD.
- md_op = (ALUOp==000) & funct7_0. When md_op=1, ALU_control=0000.
- M-op funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
  - IDLE: accept when valid_in & md_op & !kill. Latch opA, opB, funct3 → PREP.
  - PREP (1 cycle): take absolute values of the signed operands; load the iteration counter with N = XLEN/BITS_PER_CYCLE. Special cases go directly to DONE with the result preloaded:
    - divide by zero: DIV/DIVU → all ones; REM/REMU → opA.
    - signed overflow (opA = 1<<(XLEN-1), opB = all ones): DIV → opA; REM → 0.
    - otherwise → RUN.
  - RUN: N cycles of shift-add (mul, 2·XLEN product) or restoring subtract (div), BITS_PER_CYCLE steps each; counter decrements; at 0 → FIX.
  - FIX (1 cycle): apply result sign. Quotient is negative iff operand signs differ; remainder takes the dividend's sign. Select the low or high product half → DONE.
  - DONE (1 cycle): md_done=1, md_result updated → IDLE. A new M-op is only accepted from IDLE, so the same instruction is never re-accepted.
- stall = valid_in & md_op & (state != DONE). stall is high in the accept cycle and low in DONE, which lets the pipeline advance.
- Latency, counting the accept edge as edge 0:
  - normal: md_done high during cycle N+3; N+3 stall cycles.
  - special case: md_done high during cycle 2.
- kill in any non-IDLE state → IDLE next edge. md_done is not asserted and md_result is unchanged. kill has priority over accept.
- RST: state=IDLE, counter=0, md_done=0, md_result=0, internal registers=0. Mid-operation reset discards the operation.
- Arithmetic is two's complement modulo 2^XLEN. MULHSU treats opA as signed and opB as unsigned.

Test Plan:
- Decode sweep: ALUOp=000, funct3=101, funct7_5=1 → 0111. ALUOp=001, funct3=001 → 1010. ALUOp=011, funct3=000, funct7_5=1 → 0000. ALUOp=110 → 0000. md_op=0 in every case.
- MUL opA=7, opB=0xFFFFFFFD → md_result=0xFFFFFFEB. md_done in cycle 35 (N=32); stall high for cycles 0–34.
- MULH opA=opB=0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100. DIV 0x80000000/0xFFFFFFFF → 0x80000000. All special cases: md_done in cycle 2.
- Abort: kill at cycle 10 of a DIV → IDLE at cycle 11, no md_done, md_result keeps its prior value. Separately, RST at cycle 10 → md_result=0, stall follows valid_in & md_op from IDLE.
- Back-to-back MUL then DIV with valid_in held high: each accepted exactly once, two md_done pulses. Repeat with BITS_PER_CYCLE=4: normal latency becomes 11 cycles.
